axi_full_burst_master: RTL and testbench
========================================

Name: axi_full_burst_master

Overview:
AXI4 full master that issues single INCR bursts on behalf of a local command port. It is the initiator counterpart to the team's AXI4 full slave memory. Write data arrives on a local valid/ready stream and read data leaves on one. It is used by the hardware accelerator to move words to and from the PL-side memory over m_axi_full_data, and by the bench to drive the slave memory.

Parameters:
C_m_axi_full_data_ID_WIDTH, 1, AXI ID width; all IDs driven 0.
C_m_axi_full_data_ADDR_WIDTH, 32, byte address width.
C_m_axi_full_data_DATA_WIDTH, 32, data width; must be 32 or 64.
C_fsm_width, 8, state register width.

Ports:
axi_aclk  in  1  clock; all logic on rising edge.
axi_areset  in  1  reset, asynchronous, active-high.
cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
cmd_write  in  1  1 = write burst, 0 = read burst.
cmd_addr  in  ADDR_WIDTH  start byte address; low log2(DATA_WIDTH/8) bits are forced to 0.
cmd_len  in  8  beats minus 1 (AXI len encoding).
wr_data / wr_valid / wr_ready  in / in / out  DATA_WIDTH / 1 / 1  write-data stream.
rd_data / rd_valid / rd_ready  out / out / in  DATA_WIDTH / 1 / 1  read-data stream.
rd_last  out  1  marks the final read beat.
done  out  1  one-cycle pulse at the end of each command.
err  out  1  valid with done: 1 = SLVERR/DECERR, rlast mismatch, or rejected command.
m_axi_full_data_awid / awaddr / awlen / awsize / awburst / awvalid  out  ID / ADDR / 8 / 3 / 2 / 1
m_axi_full_data_awready  in  1
m_axi_full_data_wdata / wstrb / wlast / wvalid  out  DATA / DATA/8 / 1 / 1
m_axi_full_data_wready  in  1
m_axi_full_data_bid / bresp / bvalid  in  ID / 2 / 1
m_axi_full_data_bready  out  1
m_axi_full_data_arid / araddr / arlen / arsize / arburst / arvalid  out  ID / ADDR / 8 / 3 / 2 / 1
m_axi_full_data_arready  in  1
m_axi_full_data_rid / rdata / rresp / rlast / rvalid  in  ID / DATA / 2 / 1 / 1
m_axi_full_data_rready  out  1

Behaviour:
- Reset: while axi_areset = 1 all valid outputs, ready outputs, done, err, counters and addr/len registers are 0, and state = IDLE. Asserting reset mid-burst abandons the burst immediately; no completion is generated.
- Constants: awsize = arsize = log2(DATA_WIDTH/8); awburst = arburst = 2'b01 (INCR); IDs = 0; wstrb all ones.
- States: IDLE, W_ADDR, W_DATA, W_RESP, R_ADDR, R_DATA, DONE.
- IDLE: cmd_ready = 1.
  - On cmd_valid & cmd_ready, latch addr and len and clear the beat counter and error flag.
  - If (addr mod 4096) + (len+1)*bytes > 4096 (4KB crossing), go to DONE with err = 1 and no bus activity.
  - Otherwise go to W_ADDR or R_ADDR according to cmd_write.
- W_ADDR / R_ADDR: awvalid/arvalid registered high on state entry and held stable until awready/arready is sampled high. Then deassert and go to W_DATA / R_DATA.
- W_DATA: combinational pass-through with wvalid = wr_valid, wr_ready = wready, and wdata = wr_data.
  - wlast = (counter == len).
  - The counter increments on each wvalid & wready.
  - On the beat with wlast, go to W_RESP.
  - wr_ready = 0 in all other states.
- W_RESP: bready = 1. On bvalid, set err = (bresp != 0) and go to DONE.
- R_DATA: pass-through with rd_valid = rvalid, rready = rd_ready, rd_data = rdata, and rd_last = (counter == len).
  - The counter increments on each rvalid & rready.
  - If rlast arrives on a beat where counter != len, or counter == len without rlast, set the error flag.
  - On the beat with counter == len, go to DONE. Any excess beats are not accepted (rready = 0 after DONE).
  - A non-zero rresp on any beat sets the error flag (sticky for the command).
- DONE: done = 1 for exactly one cycle, err valid in the same cycle, then go to IDLE. cmd_ready returns to 1 in the next cycle.
- Latency: minimum write command is cmd accept → awvalid in 1 cycle, then len+1 beats, then 1 cycle for B, then done 1 cycle after B.
- Back-pressure: stalls on any channel hold all outputs stable. A zero-wait slave sustains 1 beat per cycle.
- Only one outstanding command; no AW/W overlap; no read/write concurrency.

Test Plan:
- Write cmd addr 0x100, len 3, data 0xA0..0xA3 against the slave memory → awaddr 0x100, awlen 3, 4 beats with wlast on the 4th, done with err 0; memory words 0x100..0x10C hold 0xA0..0xA3.
- Read back addr 0x100, len 3, rd_ready toggled every other cycle → rd_data 0xA0..0xA3 in order, rd_last on the 4th beat, no dropped or duplicated beats, done with err 0.
- Cmd addr 0xFF8, len 3, 32-bit data (crosses 4KB) → no awvalid/arvalid ever asserted, done with err 1 two cycles after accept.
- Slave returns bresp 2'b10 → done with err 1; the next command is accepted normally.
- Read len 1 where the slave asserts rlast on beat 0 → err 1 with done.
- Reset pulse asserted on the 2nd beat of a len 7 write → all outputs 0 asynchronously, no done; a following cmd executes cleanly.

Source files
------------

// File: rtl/axi_full_burst_master.sv
// AXI4 full master: turns one local command into a single INCR burst on
// m_axi_full_data. Write data and read data are streamed straight through
// between the local valid/ready ports and the AXI W/R channels.
module axi_full_burst_master #(
    parameter int C_m_axi_full_data_ID_WIDTH   = 1,
    parameter int C_m_axi_full_data_ADDR_WIDTH = 32,
    parameter int C_m_axi_full_data_DATA_WIDTH = 32,
    parameter int C_fsm_width                  = 8
) (
    input  logic                                      axi_aclk,
    input  logic                                      axi_areset,
    input  logic                                      cmd_valid,
    output logic                                      cmd_ready,
    input  logic                                      cmd_write,
    input  logic [C_m_axi_full_data_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [7:0]                                cmd_len,
    input  logic [C_m_axi_full_data_DATA_WIDTH-1:0]   wr_data,
    input  logic                                      wr_valid,
    output logic                                      wr_ready,
    output logic [C_m_axi_full_data_DATA_WIDTH-1:0]   rd_data,
    output logic                                      rd_valid,
    input  logic                                      rd_ready,
    output logic                                      rd_last,
    output logic                                      done,
    output logic                                      err,
    output logic [C_m_axi_full_data_ID_WIDTH-1:0]     m_axi_full_data_awid,
    output logic [C_m_axi_full_data_ADDR_WIDTH-1:0]   m_axi_full_data_awaddr,
    output logic [7:0]                                m_axi_full_data_awlen,
    output logic [2:0]                                m_axi_full_data_awsize,
    output logic [1:0]                                m_axi_full_data_awburst,
    output logic                                      m_axi_full_data_awvalid,
    input  logic                                      m_axi_full_data_awready,
    output logic [C_m_axi_full_data_DATA_WIDTH-1:0]   m_axi_full_data_wdata,
    output logic [C_m_axi_full_data_DATA_WIDTH/8-1:0] m_axi_full_data_wstrb,
    output logic                                      m_axi_full_data_wlast,
    output logic                                      m_axi_full_data_wvalid,
    input  logic                                      m_axi_full_data_wready,
    input  logic [C_m_axi_full_data_ID_WIDTH-1:0]     m_axi_full_data_bid,
    input  logic [1:0]                                m_axi_full_data_bresp,
    input  logic                                      m_axi_full_data_bvalid,
    output logic                                      m_axi_full_data_bready,
    output logic [C_m_axi_full_data_ID_WIDTH-1:0]     m_axi_full_data_arid,
    output logic [C_m_axi_full_data_ADDR_WIDTH-1:0]   m_axi_full_data_araddr,
    output logic [7:0]                                m_axi_full_data_arlen,
    output logic [2:0]                                m_axi_full_data_arsize,
    output logic [1:0]                                m_axi_full_data_arburst,
    output logic                                      m_axi_full_data_arvalid,
    input  logic                                      m_axi_full_data_arready,
    input  logic [C_m_axi_full_data_ID_WIDTH-1:0]     m_axi_full_data_rid,
    input  logic [C_m_axi_full_data_DATA_WIDTH-1:0]   m_axi_full_data_rdata,
    input  logic [1:0]                                m_axi_full_data_rresp,
    input  logic                                      m_axi_full_data_rlast,
    input  logic                                      m_axi_full_data_rvalid,
    output logic                                      m_axi_full_data_rready
);

    localparam int AW    = C_m_axi_full_data_ADDR_WIDTH;
    localparam int BYTES = C_m_axi_full_data_DATA_WIDTH / 8;
    localparam int SIZE  = (C_m_axi_full_data_DATA_WIDTH == 64) ? 3 : 2;
    localparam logic [AW-1:0] ADDR_MASK = ~(AW'(BYTES - 1));

    typedef enum logic [C_fsm_width-1:0] {
        IDLE,
        W_ADDR,
        W_DATA,
        W_RESP,
        R_ADDR,
        R_DATA,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [7:0]      len_q, len_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            awvalid_q, awvalid_d;
    logic            arvalid_q, arvalid_d;

    logic [AW-1:0]   cmd_addr_aligned;
    logic [8:0]      cmd_beats;
    logic [13:0]     cmd_span;
    logic            cmd_crosses_4k;
    logic            last_beat;
    logic            w_beat;
    logic            r_beat;

    // IDs are always zero, so the returned IDs carry no information.
    logic            unused_ids;
    assign unused_ids = ^{m_axi_full_data_bid, m_axi_full_data_rid};

    // Burst footprint check: offset within the 4KB page plus burst bytes.
    always_comb begin
        cmd_addr_aligned = cmd_addr & ADDR_MASK;
        cmd_beats        = {1'b0, cmd_len} + 9'd1;
        cmd_span         = {2'b00, cmd_addr_aligned[11:0]} + ({5'b00000, cmd_beats} << SIZE);
        cmd_crosses_4k   = (cmd_span > 14'd4096);
    end

    assign last_beat = (cnt_q == len_q);
    assign w_beat    = (state_q == W_DATA) && wr_valid && m_axi_full_data_wready;
    assign r_beat    = (state_q == R_DATA) && m_axi_full_data_rvalid && rd_ready;

    // Next-state logic: command acceptance, burst sequencing and error collection.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d = cmd_addr_aligned;
                    len_d  = cmd_len;
                    cnt_d  = 8'd0;
                    err_d  = 1'b0;
                    if (cmd_crosses_4k) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = cmd_write ? W_ADDR : R_ADDR;
                    end
                end
            end
            W_ADDR: begin
                if (m_axi_full_data_awready) state_d = W_DATA;
            end
            W_DATA: begin
                if (w_beat) begin
                    cnt_d = cnt_q + 8'd1;
                    if (last_beat) state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (m_axi_full_data_bvalid) begin
                    err_d   = err_q | (m_axi_full_data_bresp != 2'b00);
                    state_d = DONE;
                end
            end
            R_ADDR: begin
                if (m_axi_full_data_arready) state_d = R_DATA;
            end
            R_DATA: begin
                if (r_beat) begin
                    cnt_d = cnt_q + 8'd1;
                    if ((m_axi_full_data_rlast != last_beat) || (m_axi_full_data_rresp != 2'b00))
                        err_d = 1'b1;
                    if (last_beat) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        awvalid_d = (state_d == W_ADDR);
        arvalid_d = (state_d == R_ADDR);
    end

    // State and command registers; reset abandons any burst in flight.
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            len_q     <= 8'd0;
            cnt_q     <= 8'd0;
            err_q     <= 1'b0;
            awvalid_q <= 1'b0;
            arvalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            awvalid_q <= awvalid_d;
            arvalid_q <= arvalid_d;
        end
    end

    assign cmd_ready = (state_q == IDLE) && !axi_areset;
    assign done      = (state_q == DONE);
    assign err       = (state_q == DONE) && err_q;

    assign m_axi_full_data_awid    = '0;
    assign m_axi_full_data_awaddr  = addr_q;
    assign m_axi_full_data_awlen   = len_q;
    assign m_axi_full_data_awsize  = 3'(SIZE);
    assign m_axi_full_data_awburst = 2'b01;
    assign m_axi_full_data_awvalid = awvalid_q;

    assign m_axi_full_data_wdata   = wr_data;
    assign m_axi_full_data_wstrb   = '1;
    assign m_axi_full_data_wvalid  = (state_q == W_DATA) && wr_valid;
    assign m_axi_full_data_wlast   = (state_q == W_DATA) && last_beat;
    assign wr_ready                = (state_q == W_DATA) && m_axi_full_data_wready;
    assign m_axi_full_data_bready  = (state_q == W_RESP);

    assign m_axi_full_data_arid    = '0;
    assign m_axi_full_data_araddr  = addr_q;
    assign m_axi_full_data_arlen   = len_q;
    assign m_axi_full_data_arsize  = 3'(SIZE);
    assign m_axi_full_data_arburst = 2'b01;
    assign m_axi_full_data_arvalid = arvalid_q;

    assign rd_data                 = m_axi_full_data_rdata;
    assign rd_valid                = (state_q == R_DATA) && m_axi_full_data_rvalid;
    assign rd_last                 = (state_q == R_DATA) && last_beat;
    assign m_axi_full_data_rready  = (state_q == R_DATA) && rd_ready;

endmodule

// File: tb/tb_axi_full_burst_master.sv
// Directed bench for axi_full_burst_master against a small AXI slave memory.
module tb_axi_full_burst_master;

    logic        clk;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [31:0] wr_data;
    logic        wr_valid, wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid, rd_ready, rd_last;
    logic        done, err;

    logic [0:0]  awid, bid, arid, rid;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;

    axi_full_burst_master dut (
        .axi_aclk(clk), .axi_areset(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
        .done(done), .err(err),
        .m_axi_full_data_awid(awid), .m_axi_full_data_awaddr(awaddr),
        .m_axi_full_data_awlen(awlen), .m_axi_full_data_awsize(awsize),
        .m_axi_full_data_awburst(awburst), .m_axi_full_data_awvalid(awvalid),
        .m_axi_full_data_awready(awready),
        .m_axi_full_data_wdata(wdata), .m_axi_full_data_wstrb(wstrb),
        .m_axi_full_data_wlast(wlast), .m_axi_full_data_wvalid(wvalid),
        .m_axi_full_data_wready(wready),
        .m_axi_full_data_bid(bid), .m_axi_full_data_bresp(bresp),
        .m_axi_full_data_bvalid(bvalid), .m_axi_full_data_bready(bready),
        .m_axi_full_data_arid(arid), .m_axi_full_data_araddr(araddr),
        .m_axi_full_data_arlen(arlen), .m_axi_full_data_arsize(arsize),
        .m_axi_full_data_arburst(arburst), .m_axi_full_data_arvalid(arvalid),
        .m_axi_full_data_arready(arready),
        .m_axi_full_data_rid(rid), .m_axi_full_data_rdata(rdata),
        .m_axi_full_data_rresp(rresp), .m_axi_full_data_rlast(rlast),
        .m_axi_full_data_rvalid(rvalid), .m_axi_full_data_rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave memory model with configurable B response and early-rlast fault.
    logic [31:0] mem [0:1023];
    logic        sWActive, sBValid, sRActive;
    logic [31:0] sWAddr, sRAddr;
    logic [7:0]  sRCnt, sRLen;
    logic [1:0]  cfgBresp;
    logic        cfgEarlyLast;

    assign awready = !sWActive && !sBValid;
    assign wready  = sWActive;
    assign bvalid  = sBValid;
    assign bresp   = sBValid ? cfgBresp : 2'b00;
    assign bid     = 1'b0;
    assign arready = !sRActive;
    assign rvalid  = sRActive;
    assign rdata   = mem[sRAddr[11:2]];
    assign rresp   = 2'b00;
    assign rid     = 1'b0;
    assign rlast   = sRActive && (cfgEarlyLast ? (sRCnt == 8'd0) : (sRCnt == sRLen));

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sWActive <= 1'b0;
            sBValid  <= 1'b0;
            sRActive <= 1'b0;
            sWAddr   <= 32'd0;
            sRAddr   <= 32'd0;
            sRCnt    <= 8'd0;
            sRLen    <= 8'd0;
        end else begin
            if (awvalid && awready) begin
                sWActive <= 1'b1;
                sWAddr   <= awaddr;
            end
            if (wvalid && wready) begin
                mem[sWAddr[11:2]] <= wdata;
                sWAddr <= sWAddr + 32'd4;
                if (wlast) begin
                    sWActive <= 1'b0;
                    sBValid  <= 1'b1;
                end
            end
            if (sBValid && bready) sBValid <= 1'b0;
            if (arvalid && arready) begin
                sRActive <= 1'b1;
                sRAddr   <= araddr;
                sRCnt    <= 8'd0;
                sRLen    <= arlen;
            end
            if (rvalid && rready) begin
                sRAddr <= sRAddr + 32'd4;
                sRCnt  <= sRCnt + 8'd1;
                if (sRCnt == sRLen) sRActive <= 1'b0;
            end
        end
    end

    // Local write-data source and bus/read-stream monitors.
    logic [31:0] wrWords [0:7];
    logic [3:0]  wrIdx;
    logic [3:0]  wrCount;
    logic        wrEnable;
    logic        tbLoad;
    logic        rdToggle;
    int          wBeats, wlastCount, wlastIdx, doneCount, rdCnt;
    logic [31:0] awaddrSeen;
    logic [7:0]  awlenSeen;
    logic [2:0]  awsizeSeen;
    logic [1:0]  awburstSeen;
    logic [3:0]  wstrbSeen;
    logic        sawAddrValid;
    logic [31:0] rdBuf [0:15];
    logic [15:0] rdLastBits;

    assign wr_valid = wrEnable && (wrIdx < wrCount);
    assign wr_data  = wrWords[wrIdx[2:0]];

    always @(posedge clk) begin
        if (tbLoad) begin
            wrIdx <= 4'd0; wBeats <= 0; wlastCount <= 0; wlastIdx <= -1;
            doneCount <= 0; rdCnt <= 0; rdLastBits <= 16'd0; sawAddrValid <= 1'b0;
            awaddrSeen <= 32'd0; awlenSeen <= 8'd0; awsizeSeen <= 3'd0;
            awburstSeen <= 2'd0; wstrbSeen <= 4'd0;
        end else begin
            if (wr_valid && wr_ready) wrIdx <= wrIdx + 4'd1;
            if (awvalid || arvalid) sawAddrValid <= 1'b1;
            if (awvalid && awready) begin
                awaddrSeen <= awaddr; awlenSeen <= awlen;
                awsizeSeen <= awsize; awburstSeen <= awburst;
            end
            if (wvalid && wready) begin
                wBeats    <= wBeats + 1;
                wstrbSeen <= wstrb;
                if (wlast) begin
                    wlastCount <= wlastCount + 1;
                    wlastIdx   <= wBeats;
                end
            end
            if (done) doneCount <= doneCount + 1;
            if (rd_valid && rd_ready && rdCnt < 16) begin
                rdBuf[rdCnt]      <= rd_data;
                rdLastBits[rdCnt] <= rd_last;
                rdCnt             <= rdCnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rdToggle) rd_ready = ~rd_ready;
        else          rd_ready = 1'b1;
    end

    int checkCount = 0;
    int passCount  = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic isWrite, input logic [31:0] addr, input logic [7:0] len);
        logic accepted;
        @(negedge clk); tbLoad = 1'b1;
        @(negedge clk); tbLoad = 1'b0;
        cmd_valid = 1'b1; cmd_write = isWrite; cmd_addr = addr; cmd_len = len;
        accepted = 1'b0;
        for (int i = 0; i < 50 && !accepted; i++) begin
            if (cmd_ready) begin
                @(posedge clk); #1;
                accepted = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        cmd_valid = 1'b0;
        if (!accepted) checkOutput("cmd_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic waitDone(input string tag, output logic gotErr, output int cycles);
        logic found;
        found = 1'b0; gotErr = 1'b0; cycles = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            cycles++;
            if (done) begin
                found  = 1'b1;
                gotErr = err;
            end
        end
        if (!found) checkOutput({tag, "_done_timeout"}, 64'd0, 64'd1);
    endtask

    logic gotErr;
    int   cycles;

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'd0; cmd_len = 8'd0;
        wrEnable = 1'b0; wrCount = 4'd0; tbLoad = 1'b0; rdToggle = 1'b0;
        cfgBresp = 2'b00; cfgEarlyLast = 1'b0;
        for (int i = 0; i < 8; i++) wrWords[i] = 32'd0;

        repeat (3) @(negedge clk);
        checkOutput("reset_outputs", {52'd0, awvalid, arvalid, wvalid, wlast, wr_ready, bready,
                    rready, rd_valid, rd_last, done, err, cmd_ready}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_cmd_ready", {63'd0, cmd_ready}, 64'd1);

        // Write 0xA0..0xA3 to 0x100
        for (int i = 0; i < 4; i++) wrWords[i] = 32'hA0 + i;
        wrCount = 4'd4; wrEnable = 1'b1;
        applyStimulus(1'b1, 32'h100, 8'd3);
        waitDone("wr", gotErr, cycles);
        checkOutput("wr_err", {63'd0, gotErr}, 64'd0);
        checkOutput("wr_latency", 64'(cycles), 64'd7);
        checkOutput("wr_awaddr", {32'd0, awaddrSeen}, 64'h100);
        checkOutput("wr_awlen", {56'd0, awlenSeen}, 64'd3);
        checkOutput("wr_awsize_burst", {59'd0, awsizeSeen, awburstSeen}, {59'd0, 3'd2, 2'b01});
        checkOutput("wr_wstrb", {60'd0, wstrbSeen}, 64'hF);
        checkOutput("wr_beats", 64'(wBeats), 64'd4);
        checkOutput("wr_wlast_idx", 64'(wlastIdx), 64'd3);
        checkOutput("wr_wlast_count", 64'(wlastCount), 64'd1);
        repeat (2) @(negedge clk);
        checkOutput("wr_done_pulses", 64'(doneCount), 64'd1);
        for (int i = 0; i < 4; i++)
            checkOutput("wr_mem_word", {32'd0, mem[10'h40 + 10'(i)]}, 64'hA0 + 64'(i));
        wrEnable = 1'b0;

        // Read back with rd_ready toggling
        rdToggle = 1'b1;
        applyStimulus(1'b0, 32'h100, 8'd3);
        waitDone("rd", gotErr, cycles);
        rdToggle = 1'b0;
        checkOutput("rd_err", {63'd0, gotErr}, 64'd0);
        checkOutput("rd_beats", 64'(rdCnt), 64'd4);
        for (int i = 0; i < 4; i++)
            checkOutput("rd_data", {32'd0, rdBuf[i]}, 64'hA0 + 64'(i));
        checkOutput("rd_last_bits", {48'd0, rdLastBits}, 64'h8);

        // 4KB crossing is rejected without bus activity
        applyStimulus(1'b1, 32'hFF8, 8'd3);
        waitDone("xing", gotErr, cycles);
        checkOutput("xing_err", {63'd0, gotErr}, 64'd1);
        checkOutput("xing_latency_ok", {63'd0, (cycles >= 1 && cycles <= 2)}, 64'd1);
        repeat (2) @(negedge clk);
        checkOutput("xing_no_addr_valid", {63'd0, sawAddrValid}, 64'd0);

        // SLVERR write response, then a normal read
        cfgBresp = 2'b10;
        wrWords[0] = 32'h55; wrCount = 4'd1; wrEnable = 1'b1;
        applyStimulus(1'b1, 32'h200, 8'd0);
        waitDone("bresp", gotErr, cycles);
        checkOutput("bresp_err", {63'd0, gotErr}, 64'd1);
        cfgBresp = 2'b00; wrEnable = 1'b0;
        applyStimulus(1'b0, 32'h200, 8'd0);
        waitDone("after_bresp", gotErr, cycles);
        checkOutput("after_bresp_err", {63'd0, gotErr}, 64'd0);
        checkOutput("after_bresp_data", {32'd0, rdBuf[0]}, 64'h55);

        // Early rlast on a two-beat read
        cfgEarlyLast = 1'b1;
        applyStimulus(1'b0, 32'h100, 8'd1);
        waitDone("early_rlast", gotErr, cycles);
        checkOutput("early_rlast_err", {63'd0, gotErr}, 64'd1);
        cfgEarlyLast = 1'b0;

        // Reset on the second beat of an eight-beat write
        for (int i = 0; i < 8; i++) wrWords[i] = 32'hC0 + i;
        wrCount = 4'd8; wrEnable = 1'b1;
        applyStimulus(1'b1, 32'h300, 8'd7);
        for (int i = 0; i < 50 && wBeats < 1; i++) @(negedge clk);
        checkOutput("mid_reset_in_beat2", {63'd0, wvalid}, 64'd1);
        rst = 1'b1;
        #1;
        checkOutput("mid_reset_outputs", {52'd0, awvalid, arvalid, wvalid, wlast, wr_ready, bready,
                    rready, rd_valid, rd_last, done, err, cmd_ready}, 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("mid_reset_no_done", 64'(doneCount), 64'd0);
        wrEnable = 1'b0;

        // Clean command after the reset
        wrWords[0] = 32'h11; wrWords[1] = 32'h22; wrCount = 4'd2; wrEnable = 1'b1;
        applyStimulus(1'b1, 32'h400, 8'd1);
        waitDone("post_reset_wr", gotErr, cycles);
        checkOutput("post_reset_wr_err", {63'd0, gotErr}, 64'd0);
        wrEnable = 1'b0;
        applyStimulus(1'b0, 32'h400, 8'd1);
        waitDone("post_reset_rd", gotErr, cycles);
        checkOutput("post_reset_rd_err", {63'd0, gotErr}, 64'd0);
        checkOutput("post_reset_rd_d0", {32'd0, rdBuf[0]}, 64'h11);
        checkOutput("post_reset_rd_d1", {32'd0, rdBuf[1]}, 64'h22);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
